fifo_flush_burst: RTL and testbench

Single-clock, parametrised successor to the flush FIFO: narrow entries are written one per cycle and read out either singly (pop) or as a packed burst of up to BURST entries, with missing lanes padded with a fixed pattern. It adds a drain mode that issues back-to-back bursts until the FIFO is empty, valid/ready backpressure on the read side, a level count, and sticky overflow/underflow flags. It sits between a nibble-rate producer and a word-rate consumer inside one clock domain.

---
 rtl/fifo_flush_pkg.sv | 21 ++
 rtl/fifo_flush_lane_mux.sv | 27 ++
 rtl/fifo_flush_burst.sv | 137 +++++++++++++
 tb/tb_fifo_flush_burst.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/fifo_flush_pkg.sv
// Shared state encoding, default parameters and width helpers for the burst-read flush FIFO.
package fifo_flush_pkg;
  typedef enum logic {ST_IDLE = 1'b0, ST_DRAIN = 1'b1} state_t;

  localparam int DEF_DATA_W = 4;
  localparam int DEF_DEPTH  = 32;
  localparam int DEF_BURST  = 8;
  localparam logic [DEF_DATA_W-1:0] DEF_PAD = 4'hC;

  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic int lvl_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int cnt_w(input int burst);
    return $clog2(burst + 1);
  endfunction
endpackage

// File: rtl/fifo_flush_lane_mux.sv
// Gathers up to BURST entries starting at the read address, wrapping through storage;
// lanes at or beyond the live level are forced to PAD so stale storage never leaks out.
module fifo_flush_lane_mux
  import fifo_flush_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int BURST  = DEF_BURST,
  parameter logic [DATA_W-1:0] PAD = DATA_W'(DEF_PAD),
  localparam int AW    = $clog2(DEPTH),
  localparam int LVL_W = lvl_w(DEPTH),
  localparam int CNT_W = cnt_w(BURST)
) (
  input  logic [DEPTH-1:0][DATA_W-1:0] i_mem,
  input  logic [AW-1:0]                i_rd_addr,
  input  logic [LVL_W-1:0]             i_level,
  output logic [BURST-1:0][DATA_W-1:0] o_lanes,
  output logic [CNT_W-1:0]             o_count
);
  for (genvar g = 0; g < BURST; g++) begin : g_lane
    logic [AW-1:0] w_addr;
    assign w_addr     = i_rd_addr + AW'(g);
    assign o_lanes[g] = (LVL_W'(g) < i_level) ? i_mem[w_addr] : PAD;
  end

  assign o_count = (i_level > LVL_W'(BURST)) ? CNT_W'(BURST) : CNT_W'(i_level);
endmodule

// File: rtl/fifo_flush_burst.sv
// Narrow-in / burst-out FIFO with pop, flush and drain commands, one registered output slot
// under valid/ready backpressure, and sticky overflow/underflow flags.
module fifo_flush_burst
  import fifo_flush_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int BURST  = DEF_BURST,
  parameter logic [DATA_W-1:0] PAD = DATA_W'(DEF_PAD),
  localparam int AW    = $clog2(DEPTH),
  localparam int PTR_W = ptr_w(DEPTH),
  localparam int LVL_W = lvl_w(DEPTH),
  localparam int CNT_W = cnt_w(BURST)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      wr_valid_i,
  input  logic [DATA_W-1:0]         wr_data_i,
  output logic                      wr_ready_o,
  input  logic                      pop_i,
  input  logic                      flush_i,
  input  logic                      drain_i,
  output logic                      rd_valid_o,
  input  logic                      rd_ready_i,
  output logic [DATA_W*BURST-1:0]   rd_data_o,
  output logic [CNT_W-1:0]          rd_count_o,
  output logic [LVL_W-1:0]          level_o,
  output logic                      empty_o,
  output logic                      full_o,
  output logic                      drain_done_o,
  output logic                      overflow_o,
  output logic                      underflow_o,
  input  logic                      clear_err_i
);
  logic [DEPTH-1:0][DATA_W-1:0] r_mem;
  logic [PTR_W-1:0]             r_wr_ptr, r_rd_ptr;
  logic [BURST-1:0][DATA_W-1:0] r_data;
  logic [CNT_W-1:0]             r_cnt;
  logic                         r_vld, r_done, r_ovf, r_udf;
  state_t                       r_state;

  logic [LVL_W-1:0]             w_level;
  logic                         w_empty, w_full, w_wr_acc, w_slot_free;
  logic                         w_idle_cmd, w_do_burst, w_do_pop, w_pop_ok, w_pop_udf;
  logic [BURST-1:0][DATA_W-1:0] w_lanes, w_pop_word;
  logic [CNT_W-1:0]             w_cnt;
  logic [PTR_W-1:0]             w_taken;

  assign w_level  = LVL_W'(r_wr_ptr - r_rd_ptr);
  assign w_empty  = (r_wr_ptr == r_rd_ptr);
  assign w_full   = (r_wr_ptr[PTR_W-1] != r_rd_ptr[PTR_W-1]) &&
                    (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_wr_acc = wr_valid_i && !w_full;

  // Drain owns the slot while active; a drain request in IDLE masks flush/pop that cycle.
  assign w_slot_free = !r_vld || rd_ready_i;
  assign w_idle_cmd  = w_slot_free && (r_state == ST_IDLE) && !drain_i;
  assign w_do_burst  = (w_slot_free && (r_state == ST_DRAIN)) || (w_idle_cmd && flush_i);
  assign w_do_pop    = w_idle_cmd && !flush_i && pop_i;
  assign w_pop_ok    = w_do_pop && !w_empty;
  assign w_pop_udf   = w_do_pop && w_empty;

  fifo_flush_lane_mux #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .BURST(BURST), .PAD(PAD)
  ) u_mux (
    .i_mem     (r_mem),
    .i_rd_addr (r_rd_ptr[AW-1:0]),
    .i_level   (w_level),
    .o_lanes   (w_lanes),
    .o_count   (w_cnt)
  );

  always_comb begin
    w_pop_word    = {BURST{PAD}};
    w_pop_word[0] = w_lanes[0];
  end

  assign w_taken = w_do_burst ? PTR_W'(w_cnt) : (w_pop_ok ? PTR_W'(1) : '0);

  always_ff @(posedge clk) begin
    if (w_wr_acc) r_mem[r_wr_ptr[AW-1:0]] <= wr_data_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_data   <= '0;
      r_cnt    <= '0;
      r_vld    <= 1'b0;
      r_done   <= 1'b0;
      r_ovf    <= 1'b0;
      r_udf    <= 1'b0;
      r_state  <= ST_IDLE;
    end else begin
      r_done <= 1'b0;
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      r_rd_ptr <= r_rd_ptr + w_taken;

      if (w_do_burst) begin
        r_vld  <= 1'b1;
        r_data <= w_lanes;
        r_cnt  <= w_cnt;
      end else if (w_pop_ok) begin
        r_vld  <= 1'b1;
        r_data <= w_pop_word;
        r_cnt  <= CNT_W'(1);
      end else if (rd_ready_i) begin
        r_vld  <= 1'b0;
      end

      case (r_state)
        ST_IDLE:  if (drain_i) r_state <= ST_DRAIN;
        ST_DRAIN: if (w_slot_free && (w_level <= LVL_W'(BURST))) begin
          r_done  <= 1'b1;
          r_state <= ST_IDLE;
        end
        default:  r_state <= ST_IDLE;
      endcase

      // Set wins over clear in the same cycle.
      r_ovf <= (wr_valid_i && w_full) || (r_ovf && !clear_err_i);
      r_udf <= w_pop_udf || (r_udf && !clear_err_i);
    end
  end

  assign wr_ready_o   = !w_full;
  assign full_o       = w_full;
  assign empty_o      = w_empty;
  assign level_o      = w_level;
  assign rd_valid_o   = r_vld;
  assign rd_data_o    = r_data;
  assign rd_count_o   = r_cnt;
  assign drain_done_o = r_done;
  assign overflow_o   = r_ovf;
  assign underflow_o  = r_udf;
endmodule

// File: tb/tb_fifo_flush_burst.sv
// Directed bench: expected words go into a scoreboard queue; a negedge monitor checks each accepted word.
module tb_fifo_flush_burst;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        wr_valid_i = 1'b0;
  logic [3:0]  wr_data_i = '0;
  logic        wr_ready_o;
  logic        pop_i = 1'b0, flush_i = 1'b0, drain_i = 1'b0;
  logic        rd_valid_o;
  logic        rd_ready_i = 1'b1;
  logic [31:0] rd_data_o;
  logic [3:0]  rd_count_o;
  logic [5:0]  level_o;
  logic        empty_o, full_o, drain_done_o, overflow_o, underflow_o;
  logic        clear_err_i = 1'b0;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  cnt;
    logic        done;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_err = 0;

  fifo_flush_burst dut (
    .clk(clk), .rst_n(rst_n),
    .wr_valid_i(wr_valid_i), .wr_data_i(wr_data_i), .wr_ready_o(wr_ready_o),
    .pop_i(pop_i), .flush_i(flush_i), .drain_i(drain_i),
    .rd_valid_o(rd_valid_o), .rd_ready_i(rd_ready_i),
    .rd_data_o(rd_data_o), .rd_count_o(rd_count_o),
    .level_o(level_o), .empty_o(empty_o), .full_o(full_o),
    .drain_done_o(drain_done_o), .overflow_o(overflow_o), .underflow_o(underflow_o),
    .clear_err_i(clear_err_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] d);
    wr_valid_i = 1'b1; wr_data_i = d;
    tick();
    wr_valid_i = 1'b0;
  endtask

  task automatic do_flush();
    flush_i = 1'b1; tick(); flush_i = 1'b0;
  endtask

  task automatic do_pop();
    pop_i = 1'b1; tick(); pop_i = 1'b0;
  endtask

  task automatic do_drain();
    drain_i = 1'b1; tick(); drain_i = 1'b0;
  endtask

  task automatic expect_word(input logic [31:0] d, input logic [3:0] c, input logic dn);
    exp_t e;
    e.data = d; e.cnt = c; e.done = dn;
    q.push_back(e);
  endtask

  // Monitor: every accepted word is compared against the head of the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && rd_valid_o && rd_ready_i) begin
        if (q.size() == 0) begin
          chk("unexpected_word", {32'h0, rd_data_o}, 64'hDEAD_BEEF_0000_0000);
        end else begin
          e = q.pop_front();
          chk("word_data", {32'h0, rd_data_o}, {32'h0, e.data});
          chk("word_count", {60'h0, rd_count_o}, {60'h0, e.cnt});
          chk("word_done", {63'h0, drain_done_o}, {63'h0, e.done});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #2 rst_n = 1'b0;
    #1;
    chk("rst_valid", {63'h0, rd_valid_o}, 64'h0);
    chk("rst_data", {32'h0, rd_data_o}, 64'h0);
    chk("rst_count", {60'h0, rd_count_o}, 64'h0);
    chk("rst_level", {58'h0, level_o}, 64'h0);
    chk("rst_empty", {63'h0, empty_o}, 64'h1);
    chk("rst_full", {63'h0, full_o}, 64'h0);
    chk("rst_wr_ready", {63'h0, wr_ready_o}, 64'h1);
    chk("rst_flags", {61'h0, drain_done_o, overflow_o, underflow_o}, 64'h0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Short flush
    wr(4'h1); wr(4'h2); wr(4'h3);
    chk("level3", {58'h0, level_o}, 64'd3);
    expect_word(32'hCCCCC321, 4'd3, 1'b0);
    do_flush();
    chk("flush_level0", {58'h0, level_o}, 64'd0);
    tick();

    // Drain of 10 entries: two bursts, done on the second
    for (int i = 0; i < 10; i++) wr(4'(i));
    expect_word(32'h76543210, 4'd8, 1'b0);
    expect_word(32'hCCCCCC98, 4'd2, 1'b1);
    do_drain();
    tick(); tick();
    chk("drain_level0", {58'h0, level_o}, 64'd0);
    tick();
    chk("drain_done_pulse", {63'h0, drain_done_o}, 64'h0);

    // Fill, overflow, drain, underflow, sticky/clear
    for (int i = 0; i < 32; i++) wr(4'(i));
    chk("full_level", {58'h0, level_o}, 64'd32);
    chk("full_flag", {62'h0, full_o, wr_ready_o}, 64'b10);
    wr(4'h5);
    chk("ovf_set", {63'h0, overflow_o}, 64'h1);
    chk("ovf_level", {58'h0, level_o}, 64'd32);
    expect_word(32'h76543210, 4'd8, 1'b0);
    expect_word(32'hFEDCBA98, 4'd8, 1'b0);
    expect_word(32'h76543210, 4'd8, 1'b0);
    expect_word(32'hFEDCBA98, 4'd8, 1'b1);
    do_drain();
    tick(); tick(); tick(); tick();
    do_pop();
    chk("udf_set", {63'h0, underflow_o}, 64'h1);
    chk("udf_no_valid", {63'h0, rd_valid_o}, 64'h0);
    chk("ovf_sticky", {63'h0, overflow_o}, 64'h1);
    clear_err_i = 1'b1; tick(); clear_err_i = 1'b0;
    chk("clear_flags", {62'h0, overflow_o, underflow_o}, 64'h0);
    clear_err_i = 1'b1; pop_i = 1'b1; tick(); clear_err_i = 1'b0; pop_i = 1'b0;
    chk("set_beats_clear", {63'h0, underflow_o}, 64'h1);
    clear_err_i = 1'b1; tick(); clear_err_i = 1'b0;

    // Backpressure: held word stays, flush ignored, then served after release
    rd_ready_i = 1'b0;
    wr(4'hA); wr(4'hB);
    expect_word(32'hCCCCCCBA, 4'd2, 1'b0);
    do_flush();
    wr(4'h5); wr(4'h6);
    do_flush();
    chk("held_data", {32'h0, rd_data_o}, 64'hCCCCCCBA);
    chk("held_valid", {63'h0, rd_valid_o}, 64'h1);
    chk("ignored_level", {58'h0, level_o}, 64'd2);
    expect_word(32'hCCCCCC65, 4'd2, 1'b0);
    rd_ready_i = 1'b1; flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    tick();
    chk("release_level", {58'h0, level_o}, 64'd0);

    // Pointer wrap from a fresh reset
    rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
    for (int i = 0; i < 30; i++) begin
      expect_word({28'hCCCCCCC, 4'(i)}, 4'd1, 1'b0);
      wr(4'(i));
      do_pop();
    end
    for (int i = 1; i <= 6; i++) wr(4'(i));
    expect_word(32'hCC654321, 4'd6, 1'b0);
    do_flush();
    tick();
    chk("wrap_level", {58'h0, level_o}, 64'd0);

    // Reset in the middle of a drain
    for (int i = 0; i < 20; i++) wr(4'(i));
    expect_word(32'h76543210, 4'd8, 1'b0);
    do_drain();
    tick();
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", {63'h0, rd_valid_o}, 64'h0);
    chk("mid_rst_level", {58'h0, level_o}, 64'd0);
    chk("mid_rst_data", {28'h0, rd_count_o, rd_data_o}, 64'h0);
    chk("mid_rst_done", {63'h0, drain_done_o}, 64'h0);
    tick();
    rst_n = 1'b1;
    tick();

    // Flush on empty: count-0 marker, no underflow; then drain of empty takes one cycle
    expect_word(32'hCCCCCCCC, 4'd0, 1'b0);
    do_flush();
    chk("empty_flush_udf", {63'h0, underflow_o}, 64'h0);
    expect_word(32'hCCCCCCCC, 4'd0, 1'b1);
    do_drain();
    tick();
    tick(); tick();
    chk("sb_drained", 64'(q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
